// File: rtl/sync_memory_dp_if.sv
// Bus bundle for sync_memory_dp: one write port, one read port and status.
// The master modport belongs to the requester; the slave modport belongs to the memory.
interface sync_memory_dp_if #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
) ();

  logic                r_en;
  logic [ADDR_LEN-1:0] r_addr;
  logic                w_en;
  logic [ADDR_LEN-1:0] w_addr;
  logic [WORD_LEN-1:0] data_in;
  logic [WORD_LEN-1:0] data_out;
  logic                r_valid;
  logic                ready;
  logic                err;

  modport master (
    output r_en, r_addr, w_en, w_addr, data_in,
    input  data_out, r_valid, ready, err
  );

  modport slave (
    input  r_en, r_addr, w_en, w_addr, data_in,
    output data_out, r_valid, ready, err
  );

endinterface

// File: rtl/sync_memory_dp.sv
// Simple-dual-port synchronous memory with registered read data, selectable
// read-during-write behaviour, out-of-range detection and a post-reset zero fill.
module sync_memory_dp #(
  parameter int ADDR_LEN  = 8,
  parameter int WORD_LEN  = 8,
  parameter int MEM_SIZE  = 256,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_memory_dp_if.slave  bus
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam state_e              RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam int                  LAST_IDX    = MEM_SIZE - 1;
  localparam logic [ADDR_LEN-1:0] FILL_LAST   = LAST_IDX[ADDR_LEN-1:0];
  localparam logic [ADDR_LEN:0]   SIZE_EXT    = MEM_SIZE[ADDR_LEN:0];

  logic [WORD_LEN-1:0] mem [MEM_SIZE];

  state_e              state_q,    state_d;
  logic [ADDR_LEN-1:0] fill_cnt_q, fill_cnt_d;
  logic                ready_q,    ready_d;
  logic [WORD_LEN-1:0] data_out_q, data_out_d;
  logic                r_valid_q,  r_valid_d;
  logic                err_q,      err_d;

  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_waddr;
  logic [WORD_LEN-1:0] mem_wdata;

  logic                r_oor;
  logic                w_oor;
  logic                rdw_bypass;
  logic [WORD_LEN-1:0] rd_word;

  // Zero-extend so a full 2^ADDR_LEN array compares correctly.
  assign r_oor = ({1'b0, bus.r_addr} >= SIZE_EXT);
  assign w_oor = ({1'b0, bus.w_addr} >= SIZE_EXT);

  assign rdw_bypass = (RDW_MODE != 0) && bus.w_en && !w_oor &&
                      (bus.w_addr == bus.r_addr);

  assign rd_word = mem[bus.r_addr];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    ready_d    = ready_q;

    unique case (state_q)
      ST_INIT: begin
        fill_cnt_d = fill_cnt_q + ADDR_LEN'(1);
        if (fill_cnt_q == FILL_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // User accesses are only honoured once ready is visible on the port.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = fill_cnt_q;
    mem_wdata  = '0;
    data_out_d = data_out_q;
    r_valid_d  = 1'b0;
    err_d      = 1'b0;

    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (ready_q) begin
      if (bus.w_en && !w_oor) begin
        mem_we    = 1'b1;
        mem_waddr = bus.w_addr;
        mem_wdata = bus.data_in;
      end
      if (bus.r_en) begin
        r_valid_d = 1'b1;
        if (r_oor) begin
          data_out_d = '0;
        end else if (rdw_bypass) begin
          data_out_d = bus.data_in;
        end else begin
          data_out_d = rd_word;
        end
      end
      err_d = (bus.r_en && r_oor) || (bus.w_en && w_oor);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      fill_cnt_q <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      r_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      r_valid_q  <= r_valid_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the INIT fill clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;

endmodule

// File: doc/sync_memory_dp.md
Name: sync_memory_dp

Overview:
- Parametrised, fully synchronous simple-dual-port memory: one write port, one read port, independent addresses.
- Successor to the single-address combinational memory block.
- Adds the following:
  - registered read data with a valid strobe;
  - selectable read-during-write policy;
  - out-of-range address detection;
  - a post-reset zero-fill sequencer.
- Sits between datapath/controller blocks and storage, e.g. register files, scratch RAM, operand buffers.

Parameters:
- ADDR_LEN, 8, address width in bits; must satisfy 2^ADDR_LEN >= MEM_SIZE.
- WORD_LEN, 8, data word width in bits.
- MEM_SIZE, 256, number of words; valid addresses are 0..MEM_SIZE-1.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns data_in (write-through bypass).
- INIT_ZERO, 1, 1 = zero-fill every location after reset before accepting accesses; 0 = skip fill.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- r_en  in  1  read request, sampled at clk edge.
- r_addr  in  ADDR_LEN  read address.
- w_en  in  1  write request, sampled at clk edge.
- w_addr  in  ADDR_LEN  write address.
- data_in  in  WORD_LEN  write data.
- data_out  out  WORD_LEN  registered read data; holds its value between reads.
- r_valid  out  1  one-cycle pulse; data_out is updated this cycle.
- ready  out  1  high when user accesses are accepted.
- err  out  1  one-cycle pulse on an accepted out-of-range read or write.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, r_valid=0, err=0, ready=0, fill counter=0.
  - State goes to INIT if INIT_ZERO=1, else to RUN.
  - Array contents are not reset directly.
- FSM states:
  - INIT: each clk edge writes 0 to mem[fill_cnt], then fill_cnt increments. On the edge that writes MEM_SIZE-1, state goes to RUN and ready is registered to 1. ready therefore rises after exactly MEM_SIZE edges following reset release.
  - RUN: ready=1. This is a terminal state; only reset leaves it.
- In INIT, r_en and w_en are ignored: no array write from the user port, r_valid=0, err=0, data_out stays 0.
- Reset asserted mid-INIT restarts the fill from address 0; partially filled contents are not relied upon.
- Write (RUN): on the clk edge with w_en=1 and w_addr<MEM_SIZE, mem[w_addr] <= data_in.
- Read (RUN): on the clk edge with r_en=1, data_out <= mem[r_addr] and r_valid <= 1.
  - Latency is 1 cycle: data is visible the cycle after the request.
  - r_valid drops the following cycle unless r_en is still high. Back-to-back reads give one result per cycle.
- Read-during-write, same address, both in range:
  - RDW_MODE=0: data_out gets the pre-write contents.
  - RDW_MODE=1: data_out gets data_in.
  - The write always completes.
- Different read and write addresses in the same cycle are fully independent.
- Out of range (address >= MEM_SIZE; only reachable when MEM_SIZE < 2^ADDR_LEN):
  - Write is dropped with no array change.
  - Read gives data_out <= 0 and r_valid <= 1.
  - err <= 1 for one cycle if either port is out of range; it is a single pulse even when both ports are.
- No wrap-around: addresses are never taken modulo MEM_SIZE.
- r_en/w_en are level-sampled; no handshake stall. ready only gates acceptance.
- Widths: no arithmetic on data. fill_cnt is ADDR_LEN bits wide and the terminal compare is against MEM_SIZE-1.

Test Plan:
- Reset release, INIT_ZERO=1, MEM_SIZE=256 -> ready=0 for 256 edges, then 1. Reading addr 0x00, 0x7F and 0xFF gives data_out=0x00 with r_valid high one cycle later.
- RUN: write 0xA5 to addr 0x10, next cycle read 0x10 -> data_out=0xA5 one cycle after r_en. Hold r_en for addrs 0x10, 0x11 -> r_valid stays high and data tracks each address.
- Same-cycle write 0x3C / read of addr 0x20 holding 0x11 -> RDW_MODE=0 gives data_out=0x11; RDW_MODE=1 gives 0x3C. Both modes read back 0x3C on the next read.
- MEM_SIZE=200: write 0xFF to addr 200 -> err pulses once and no change occurs. Read addr 250 -> data_out=0x00, r_valid=1, err=1. A subsequent in-range access leaves err low.
- Assert rst_n low at fill step 100, release -> ready stays low for a full 256 edges again. During INIT, w_en=1 to addr 5 with 0x77 is ignored and a post-INIT read of addr 5 gives 0x00.
- INIT_ZERO=0 -> ready=1 on the first edge after reset release, and a write/read to addr 3 with 0x5A works immediately.
